// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target and its line front end.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_BYTE,
    ST_WR_ACK,
    ST_RD_BYTE,
    ST_RD_ACK,
    ST_WAIT_STOP
  } i2c_state_e;

  localparam logic I2C_READ  = 1'b1;
  localparam logic I2C_WRITE = 1'b0;

  // Address byte (addr + R/W) hits our address; general call (0) never hits.
  function automatic logic addr_hit(input logic [7:0] addr_byte, input logic [6:0] own);
    return (addr_byte[7:1] == own) && (own != 7'd0);
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronises raw SCL/SDA and derives edge, START and STOP events.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [SYNC_STAGES-1:0] scl_ff_q;
  logic [SYNC_STAGES-1:0] sda_ff_q;
  logic                   scl_h_q;
  logic                   sda_h_q;
  logic                   scl_s;

  assign scl_s = scl_ff_q[SYNC_STAGES-1];
  assign sda_s = sda_ff_q[SYNC_STAGES-1];

  // Synchroniser chains plus one history flop; idle bus level is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_ff_q <= '1;
      sda_ff_q <= '1;
      scl_h_q  <= 1'b1;
      sda_h_q  <= 1'b1;
    end else begin
      scl_ff_q <= {scl_ff_q[SYNC_STAGES-2:0], scl_in};
      sda_ff_q <= {sda_ff_q[SYNC_STAGES-2:0], sda_in};
      scl_h_q  <= scl_s;
      sda_h_q  <= sda_s;
    end
  end

  assign scl_rise = scl_s & ~scl_h_q;
  assign scl_fall = ~scl_s & scl_h_q;
  // SDA moving while SCL is steadily high marks bus conditions.
  assign start    = scl_s & scl_h_q & sda_h_q & ~sda_s;
  assign stop     = scl_s & scl_h_q & ~sda_h_q & sda_s;

endmodule

// File: rtl/i2c_target.sv
// 7-bit address I2C target: receives writes to a strobe interface and
// serves reads from a request interface. Never stretches SCL.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDRESS     = 7'h33,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_out,
  output logic       sda_oe,
  output logic       busy,
  output logic       addressed,
  output logic       read_write,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       tx_req,
  input  logic [7:0] tx_data,
  output logic       nack_seen
);

  logic sda_s, scl_rise, scl_fall, start, stop;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .reset    (reset),
    .scl_in   (scl_in),
    .sda_in   (sda_in),
    .sda_s    (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  i2c_state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       done_q, done_d;       // byte/ACK phase finished, act on next scl_fall
  logic       ack_q, ack_d;         // rx_ready captured with rx_valid
  logic       sda_oe_q, sda_oe_d;
  logic       busy_q, busy_d;
  logic       addr_q, addr_d;
  logic       rw_q, rw_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_req_q, tx_req_d;
  logic       tx_dly_q;
  logic [7:0] tx_buf_q, tx_buf_d;
  logic       nack_q, nack_d;
  logic [7:0] byte_in;

  assign byte_in = {shift_q[6:0], sda_s};

  // State and datapath registers; reset releases SDA immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 3'd7;
      shift_q    <= 8'd0;
      done_q     <= 1'b0;
      ack_q      <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      addr_q     <= 1'b0;
      rw_q       <= 1'b0;
      rx_data_q  <= 8'd0;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      tx_dly_q   <= 1'b0;
      tx_buf_q   <= 8'd0;
      nack_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      done_q     <= done_d;
      ack_q      <= ack_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      addr_q     <= addr_d;
      rw_q       <= rw_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
      tx_dly_q   <= tx_req_q;
      tx_buf_q   <= tx_buf_d;
      nack_q     <= nack_d;
    end
  end

  // Next-state logic: bus conditions first, then per-state bit handling.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    done_d     = done_q;
    ack_d      = ack_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    addr_d     = addr_q;
    rw_d       = rw_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    nack_d     = 1'b0;
    tx_buf_d   = tx_buf_q;
    // Read byte is captured two clocks after the request pulse.
    if (tx_dly_q) tx_buf_d = tx_data;
    if (rx_valid_q) ack_d = rx_ready;

    if (start) begin
      state_d  = ST_ADDR;
      cnt_d    = 3'd7;
      done_d   = 1'b0;
      sda_oe_d = 1'b0;
      addr_d   = 1'b0;
      busy_d   = 1'b1;
    end else if (stop) begin
      state_d  = ST_IDLE;
      done_d   = 1'b0;
      sda_oe_d = 1'b0;
      addr_d   = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_WAIT_STOP: ;
        ST_ADDR: begin
          if (scl_rise) begin
            shift_d = byte_in;
            if (cnt_q == 3'd0) done_d = 1'b1;
            else               cnt_d  = cnt_q - 3'd1;
          end else if (scl_fall && done_q) begin
            done_d = 1'b0;
            if (addr_hit(shift_q, ADDRESS)) begin
              sda_oe_d = 1'b1;
              rw_d     = shift_q[0];
              addr_d   = 1'b1;
              state_d  = ST_ADDR_ACK;
            end else begin
              state_d  = ST_WAIT_STOP;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_rise && rw_q == I2C_READ) begin
            tx_req_d = 1'b1;
          end else if (scl_fall) begin
            cnt_d = 3'd7;
            if (rw_q == I2C_READ) begin
              shift_d  = tx_buf_q;
              sda_oe_d = ~tx_buf_q[7];
              state_d  = ST_RD_BYTE;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = ST_WR_BYTE;
            end
          end
        end
        ST_WR_BYTE: begin
          if (scl_rise) begin
            shift_d = byte_in;
            if (cnt_q == 3'd0) begin
              rx_data_d  = byte_in;
              rx_valid_d = 1'b1;
              done_d     = 1'b1;
            end else begin
              cnt_d = cnt_q - 3'd1;
            end
          end else if (scl_fall && done_q) begin
            done_d   = 1'b0;
            sda_oe_d = ack_q;
            state_d  = ST_WR_ACK;
          end
        end
        ST_WR_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            cnt_d    = 3'd7;
            state_d  = ack_q ? ST_WR_BYTE : ST_WAIT_STOP;
          end
        end
        ST_RD_BYTE: begin
          if (scl_fall) begin
            if (cnt_q == 3'd0) begin
              sda_oe_d = 1'b0;
              done_d   = 1'b0;
              state_d  = ST_RD_ACK;
            end else begin
              shift_d  = {shift_q[6:0], 1'b1};
              sda_oe_d = ~shift_q[6];
              cnt_d    = cnt_q - 3'd1;
            end
          end
        end
        ST_RD_ACK: begin
          if (scl_rise) begin
            if (!sda_s) begin
              tx_req_d = 1'b1;
              done_d   = 1'b1;
            end else begin
              nack_d   = 1'b1;
              state_d  = ST_WAIT_STOP;
            end
          end else if (scl_fall && done_q) begin
            done_d   = 1'b0;
            shift_d  = tx_buf_q;
            sda_oe_d = ~tx_buf_q[7];
            cnt_d    = 3'd7;
            state_d  = ST_RD_BYTE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign sda_out    = 1'b0;
  assign sda_oe     = sda_oe_q;
  assign busy       = busy_q;
  assign addressed  = addr_q;
  assign read_write = rw_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign tx_req     = tx_req_q;
  assign nack_seen  = nack_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench: acts as the bus controller with an open-drain SDA model.
module tb_i2c_target;

  localparam int Q = 10;  // quarter SCL period in clk cycles

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_in;
  logic       sda_out, sda_oe, busy, addressed, read_write;
  logic [7:0] rx_data;
  logic       rx_valid, tx_req, nack_seen;
  logic       rx_ready = 1'b1;
  logic [7:0] tx_data = 8'h00;

  int checks = 0;
  int errors = 0;
  int n_rxv = 0, n_txr = 0, n_nack = 0, n_oe = 0, n_adr = 0, n_idle = 0;
  logic [7:0] last_rx = 8'h00;

  assign sda_in = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target dut (
    .clk        (clk),
    .reset      (reset),
    .scl_in     (scl_m),
    .sda_in     (sda_in),
    .sda_out    (sda_out),
    .sda_oe     (sda_oe),
    .busy       (busy),
    .addressed  (addressed),
    .read_write (read_write),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .tx_req     (tx_req),
    .tx_data    (tx_data),
    .nack_seen  (nack_seen)
  );

  // Event counters sampled away from the active edge
  always @(negedge clk) begin
    if (rx_valid) begin n_rxv++; last_rx = rx_data; end
    if (tx_req)    n_txr++;
    if (nack_seen) n_nack++;
    if (sda_oe)    n_oe++;
    if (addressed) n_adr++;
    if (!busy)     n_idle++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic bit_xfer(input logic b, output logic s);
    sda_m = b;    tick(Q);
    scl_m = 1'b1; tick(Q);
    s = sda_in;   tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic wbyte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_xfer(d[i], s);
    bit_xfer(1'b1, ack);
  endtask

  task automatic rbyte(output logic [7:0] d);
    logic s;
    d = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, s);
      d[i] = s;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack, s;
    logic [7:0] rb;
    int s_rxv, s_txr, s_nack, s_oe, s_adr, s_idle;

    tick(4);
    check("rst_oe", sda_oe, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_addr", addressed, 1'b0);
    check("rst_rxv", rx_valid, 1'b0);
    check("rst_out", sda_out, 1'b0);
    reset = 1'b0;
    tick(Q);

    // Write 0xA5 to 0x33
    s_rxv = n_rxv;
    bus_start();
    check("wr_busy", busy, 1'b1);
    wbyte(8'h66, ack); check("wr_aack", ack, 1'b0);
    check("wr_addressed", addressed, 1'b1);
    check("wr_rw", read_write, 1'b0);
    wbyte(8'hA5, ack); check("wr_dack", ack, 1'b0);
    check("wr_nrxv", n_rxv - s_rxv, 1);
    check("wr_data", last_rx, 8'hA5);
    bus_stop();
    check("wr_busy_end", busy, 1'b0);
    check("wr_addr_end", addressed, 1'b0);

    // Address mismatch 0x12
    s_rxv = n_rxv; s_oe = n_oe; s_adr = n_adr;
    bus_start();
    wbyte(8'h24, ack); check("mm_aack", ack, 1'b1);
    wbyte(8'h5A, ack); check("mm_dack", ack, 1'b1);
    check("mm_oe", n_oe - s_oe, 0);
    check("mm_rxv", n_rxv - s_rxv, 0);
    check("mm_adr", n_adr - s_adr, 0);
    bus_stop();

    // Read two bytes, ACK then NACK
    s_txr = n_txr; s_nack = n_nack;
    tx_data = 8'h3C;
    bus_start();
    wbyte(8'h67, ack); check("rd_aack", ack, 1'b0);
    check("rd_rw", read_write, 1'b1);
    rbyte(rb); check("rd_b0", rb, 8'h3C);
    tx_data = 8'hC3;
    bit_xfer(1'b0, s);
    rbyte(rb); check("rd_b1", rb, 8'hC3);
    bit_xfer(1'b1, s);
    check("rd_txreq", n_txr - s_txr, 2);
    check("rd_nack", n_nack - s_nack, 1);
    bus_stop();

    // Backpressure: NACK data, ignore following byte
    s_rxv = n_rxv;
    rx_ready = 1'b0;
    bus_start();
    wbyte(8'h66, ack); check("bp_aack", ack, 1'b0);
    wbyte(8'h55, ack); check("bp_dack", ack, 1'b1);
    check("bp_rxv", n_rxv - s_rxv, 1);
    check("bp_data", last_rx, 8'h55);
    s_oe = n_oe;
    wbyte(8'hFF, ack); check("bp_ignored_ack", ack, 1'b1);
    check("bp_rxv2", n_rxv - s_rxv, 1);
    check("bp_oe", n_oe - s_oe, 0);
    bus_stop();
    rx_ready = 1'b1;

    // Write then repeated START into a read
    s_rxv = n_rxv;
    bus_start();
    s_idle = n_idle;
    wbyte(8'h66, ack); check("rs_aack", ack, 1'b0);
    wbyte(8'h01, ack); check("rs_dack", ack, 1'b0);
    check("rs_data", last_rx, 8'h01);
    check("rs_rw0", read_write, 1'b0);
    tx_data = 8'h96;
    bus_start();
    wbyte(8'h67, ack); check("rs_raack", ack, 1'b0);
    check("rs_rw1", read_write, 1'b1);
    rbyte(rb); check("rs_rb", rb, 8'h96);
    bit_xfer(1'b1, s);
    check("rs_busy_held", n_idle - s_idle, 0);
    check("rs_rxv", n_rxv - s_rxv, 1);
    bus_stop();

    // Reset while target drives a 0 bit
    tx_data = 8'h00;
    bus_start();
    wbyte(8'h67, ack); check("rr_aack", ack, 1'b0);
    check("rr_drive", sda_oe, 1'b1);
    reset = 1'b1;
    #1;
    check("rr_oe_async", sda_oe, 1'b0);
    check("rr_busy", busy, 1'b0);
    check("rr_addr", addressed, 1'b0);
    scl_m = 1'b1; sda_m = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(Q);
    s_rxv = n_rxv;
    bus_start();
    wbyte(8'h66, ack); check("rr2_aack", ack, 1'b0);
    wbyte(8'h3A, ack); check("rr2_dack", ack, 1'b0);
    check("rr2_data", last_rx, 8'h3A);
    check("rr2_rxv", n_rxv - s_rxv, 1);
    bus_stop();
    check("rr2_busy", busy, 1'b0);

    tick(Q);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- 7-bit-address I2C target (responder): the peripheral end of the bus our i2c_controller drives.
- Oversamples SCL/SDA on the system clock, detects START/repeated-START/STOP, matches its own address and ACKs.
- Receives write bytes to a user strobe interface and serves read bytes from a user request interface.
- Used for FPGA-side register access by the host MCU and for loopback verification of the controller.

Parameters:
ADDRESS, 7'h33, target's 7-bit bus address.
SYNC_STAGES, 2, flip-flop stages synchronising scl_in/sda_in (min 2).

Ports:
clk  input  1  system clock; must be >= 8x the SCL frequency.
reset  input  1  asynchronous, active-high; clears all state and releases SDA.
scl_in  input  1  raw SCL from pad.
sda_in  input  1  raw SDA from pad.
sda_out  output  1  constant 0 (open-drain); routed to tristate with sda_oe.
sda_oe  output  1  1 = pull SDA low.
busy  output  1  high from START to STOP, any address.
addressed  output  1  high from matched-address ACK until STOP/START.
read_write  output  1  R/W bit of the current addressed transfer (1 = read).
rx_data  output  8  last byte written by the controller.
rx_valid  output  1  one-clk pulse; rx_data valid this cycle.
rx_ready  input  1  sampled at rx_valid; 0 makes the target NACK the byte.
tx_req  output  1  one-clk pulse; user must present the next read byte within 2 clk.
tx_data  input  8  read byte; latched 2 clk after tx_req.
nack_seen  output  1  one-clk pulse when the controller NACKs a read byte.

Behaviour:
- Reset (async): state IDLE; all outputs 0; sda_oe 0; synchronisers reset to 1.
- Synchronisers: scl_s/sda_s go through SYNC_STAGES flops plus one history flop.
- Derived events: scl_rise, scl_fall; START = sda_s falls while scl_s is 1; STOP = sda_s rises while scl_s is 1.
- START/STOP override from any state, evaluated before normal state logic:
  - START: counter = 7, sda_oe 0, addressed 0, go ADDR, busy 1.
  - STOP: go IDLE, sda_oe 0, busy 0, addressed 0.
- Sampling and driving: SDA is sampled only on scl_rise; sda_oe changes only on scl_fall (exception: release on START/STOP/reset).
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits MSB-first on scl_rise. After the 8th bit:
    - match: on the next scl_fall set sda_oe 1, latch read_write, addressed 1, go ADDR_ACK.
    - mismatch: go WAIT_STOP, never drive SDA.
  - ADDR_ACK: on scl_rise, pulse tx_req if read. On scl_fall:
    - write: release SDA, counter 7, go WR_BYTE.
    - read: load the shift register from tx_data (latched 2 clk after tx_req), drive bit7 (sda_oe = ~bit), go RD_BYTE.
  - WR_BYTE: shift on scl_rise. On the 8th bit, rx_data <= shifted byte and rx_valid pulses one clk. On the next scl_fall, sda_oe <= rx_ready (value sampled at rx_valid), go WR_ACK.
  - WR_ACK: on scl_fall, release SDA, counter 7.
    - ACKed: go WR_BYTE.
    - NACKed: go WAIT_STOP.
  - RD_BYTE: on each scl_fall drive the next bit (bits 6..0). After bit0's scl_fall+1 SCL period, i.e. on the scl_fall after bit0 is sampled, release SDA, go RD_ACK.
  - RD_ACK: on scl_rise sample SDA.
    - 0 (ACK): pulse tx_req; on scl_fall load tx_data, drive bit7, go RD_BYTE.
    - 1 (NACK): pulse nack_seen, go WAIT_STOP.
  - WAIT_STOP: SDA released; only START/STOP leave this state.
- Repeated START mid-byte: current byte is discarded, no rx_valid, re-enter ADDR.
- General call (address 0) is not supported and is treated as a mismatch.
- No clock stretching: SCL is never driven.

Decomposition:
- i2c_pkg: state encoding localparams, I2C_READ = 1, I2C_WRITE = 0.
- Sub-module i2c_line_sync: synchroniser plus edge/START/STOP detector. Instanced once; reusable by the controller bench.

Test Plan:
- Write: START, 0x66 (0x33,W), 0xA5, STOP, rx_ready = 1.
  - Expect: ACK on address and data; rx_valid once with rx_data = 0xA5; busy falls at STOP.
- Mismatch: address 0x12 W plus one byte.
  - Expect: sda_oe never 1; no rx_valid; addressed stays 0.
- Read: 0x67 (0x33,R), tx_data 0x3C then 0xC3; controller ACKs byte 1, NACKs byte 2.
  - Expect: bus bytes 0x3C, 0xC3; tx_req twice; nack_seen once.
- Backpressure: rx_ready = 0 during write of 0x55.
  - Expect: rx_valid pulses; SDA high at ACK slot; target enters WAIT_STOP and ignores further bytes.
- Repeated START: write 0x01, then repeated START, then read one byte.
  - Expect: rx_valid with 0x01; read_write flips to 1; busy stays 1 throughout.
- Reset mid-read while driving 0.
  - Expect: sda_oe drops within the same clk edge it is asserted; state IDLE; next transfer works normally.
